collatz_seq_ctrl: RTL and testbench

Sequencing controller for the Collatz iteration datapath. It accepts a start value over a valid/ready handshake and runs one Collatz step per clock (n/2 if even, 3n+1 if odd) until n reaches 1. It then presents step count, peak value and status flags over a second valid/ready handshake. It sits between the pin-level byte loader/unloader and the top-level project wrapper.

---
 rtl/collatz_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_collatz_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_seq_ctrl.sv
// Collatz sequencing controller: accepts n0, iterates one step per clock until n==1,
// then offers step count, peak value and status flags over a valid/ready handshake.
module collatz_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_value,
  input  logic              abort,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [STEP_W-1:0] out_steps,
  output logic [WIDTH-1:0]  out_peak,
  output logic              out_ovf,
  output logic              out_tmo,
  output logic              out_zero
);

  localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_n;
  logic [STEP_W-1:0] r_steps;
  logic [WIDTH-1:0]  r_peak;
  logic              r_ovf;
  logic              r_tmo;
  logic              r_zero;

  // 3n+1 carried in two extra bits so an overflow is detected rather than wrapped.
  logic [WIDTH+1:0]  w_tri;
  logic              w_tri_ovf;
  logic [WIDTH-1:0]  w_n_next;
  logic              w_n_is_one;

  assign w_tri      = ({2'b00, r_n} << 1) + {2'b00, r_n} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_tri_ovf  = |w_tri[WIDTH+1:WIDTH];
  assign w_n_next   = r_n[0] ? w_tri[WIDTH-1:0] : (r_n >> 1);
  assign w_n_is_one = (r_n == {{(WIDTH-1){1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_n         <= '0;
      r_steps     <= '0;
      r_peak      <= '0;
      r_ovf       <= 1'b0;
      r_tmo       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_n        <= in_value;
            r_peak     <= in_value;
            r_steps    <= '0;
            r_ovf      <= 1'b0;
            r_tmo      <= 1'b0;
            r_in_ready <= 1'b0;
            if (in_value == '0) begin
              r_zero      <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_zero  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (abort) begin
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (w_n_is_one) begin
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (r_steps == STEP_MAX) begin
            r_tmo       <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (r_n[0] && w_tri_ovf) begin
            r_ovf       <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_n     <= w_n_next;
            r_steps <= r_steps + 1'b1;
            if (w_n_next > r_peak) begin
              r_peak <= w_n_next;
            end
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_steps = r_steps;
  assign out_peak  = r_peak;
  assign out_ovf   = r_ovf;
  assign out_tmo   = r_tmo;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_collatz_seq_ctrl.sv
// Randomized and directed checks of collatz_seq_ctrl against a plain-arithmetic Collatz model;
// a second instance with a 4-bit step counter exercises saturation.
module tb_collatz_seq_ctrl;

  localparam int WIDTH    = 16;
  localparam int STEP_W   = 10;
  localparam int S_STEP_W = 4;
  localparam int LIMIT    = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_value;
  logic              abort;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [STEP_W-1:0] out_steps;
  logic [WIDTH-1:0]  out_peak;
  logic              out_ovf, out_tmo, out_zero;

  logic                s_in_valid, s_in_ready, s_abort, s_busy, s_out_valid, s_out_ready;
  logic [WIDTH-1:0]    s_in_value, s_out_peak;
  logic [S_STEP_W-1:0] s_out_steps;
  logic                s_out_ovf, s_out_tmo, s_out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  collatz_seq_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .abort(abort), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_steps(out_steps), .out_peak(out_peak), .out_ovf(out_ovf), .out_tmo(out_tmo),
    .out_zero(out_zero)
  );

  collatz_seq_ctrl #(.WIDTH(WIDTH), .STEP_W(S_STEP_W)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_value(s_in_value),
    .abort(s_abort), .busy(s_busy), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_steps(s_out_steps), .out_peak(s_out_peak), .out_ovf(s_out_ovf), .out_tmo(s_out_tmo),
    .out_zero(s_out_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: iterate the Collatz rules directly on integers.
  task automatic model(input int n0, input int smax, output int steps, output int peak,
                       output int ovf, output int tmo, output int zero);
    longint n;
    n = n0; steps = 0; peak = n0; ovf = 0; tmo = 0; zero = (n0 == 0);
    if (!zero) begin
      while (n != 1) begin
        if (steps == smax) begin tmo = 1; break; end
        if ((n % 2) == 1 && (3 * n + 1) > 65535) begin ovf = 1; break; end
        n = (n % 2 == 0) ? n / 2 : 3 * n + 1;
        steps++;
        if (n > peak) peak = int'(n);
      end
    end
  endtask

  // Called at a negedge. abort_at: cycle after accept at which to abort (0 = never).
  task automatic job(input int n0, input int hold, input int abort_at, input bit hold_valid);
    int e_steps, e_peak, e_ovf, e_tmo, e_zero, e_lat, lat;
    bit seen;
    model(n0, (1 << STEP_W) - 1, e_steps, e_peak, e_ovf, e_tmo, e_zero);
    e_lat = e_zero ? 1 : 2 + e_steps;
    check("ready_before_start", in_ready, 1);
    in_value  = n0[WIDTH-1:0];
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 if (!hold_valid) in_valid = 1'b0;
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clk);
      lat = c;
      if (hold_valid) in_value = WIDTH'($urandom);
      if (c == 1) begin
        check("busy_after_accept", busy, !e_zero);
        check("ready_low_after_accept", in_ready, 0);
      end
      if (abort_at != 0 && c == abort_at) begin
        abort = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        check("abort_no_valid", out_valid, 0);
        $display("job n0=%0d aborted at T+%0d", n0, abort_at);
        return;
      end
      if (out_valid) begin seen = 1; break; end
    end
    in_valid = 1'b0;
    if (!seen) begin
      check("result_timeout", 0, 1);
      return;
    end
    check("latency", lat, e_lat);
    check("steps", out_steps, e_steps);
    check("peak", out_peak, e_peak);
    check("ovf", out_ovf, e_ovf);
    check("tmo", out_tmo, e_tmo);
    check("zero", out_zero, e_zero);
    for (int h = 0; h < hold; h++) begin
      abort = (h == 0);
      @(negedge clk);
      abort = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_steps", out_steps, e_steps);
      check("hold_peak", out_peak, e_peak);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_handshake", in_ready, 1);
    check("valid_after_handshake", out_valid, 0);
    $display("job n0=%0d lat=%0d steps=%0d peak=%0d ovf=%0d tmo=%0d zero=%0d hold=%0d",
             n0, lat, out_steps, out_peak, out_ovf, out_tmo, out_zero, hold);
  endtask

  task automatic job_small(input int n0);
    int e_steps, e_peak, e_ovf, e_tmo, e_zero, lat;
    bit seen;
    model(n0, (1 << S_STEP_W) - 1, e_steps, e_peak, e_ovf, e_tmo, e_zero);
    s_in_value = n0[WIDTH-1:0];
    s_in_valid = 1'b1;
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    seen = 0; lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      lat = c;
      if (s_out_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      check("small_timeout", 0, 1);
      return;
    end
    check("small_latency", lat, e_zero ? 1 : 2 + e_steps);
    check("small_steps", s_out_steps, e_steps);
    check("small_peak", s_out_peak, e_peak);
    check("small_tmo", s_out_tmo, e_tmo);
    check("small_ovf", s_out_ovf, e_ovf);
    @(negedge clk);
    check("small_idle", s_in_ready, 1);
    $display("small n0=%0d lat=%0d steps=%0d peak=%0d tmo=%0d ovf=%0d",
             n0, lat, s_out_steps, s_out_peak, s_out_tmo, s_out_ovf);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_value = '0; abort = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_value = '0; s_abort = 1'b0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_steps", out_steps, 0);
    check("rst_peak", out_peak, 0);
    check("rst_flags", {out_ovf, out_tmo, out_zero}, 0);

    job(6, 0, 0, 0);
    job(27, 5, 0, 0);
    job(1, 0, 0, 0);
    job(0, 2, 0, 0);
    job(65535, 0, 0, 0);
    job(27, 0, 20, 0);
    job(6, 0, 0, 0);
    job(27, 3, 0, 1);
    job(6, 0, 0, 0);
    job(7, 1, 0, 0);

    // Reset during RUN drops the job.
    in_value = 16'd27; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_run_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    $display("reset during RUN");

    for (int i = 0; i < 30; i++) begin
      int n0, hold, ab, hv;
      n0   = (i % 3 == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 65535));
      hold = int'($urandom_range(0, 3));
      hv   = ($urandom_range(0, 3) == 0);
      ab   = 0;
      if ($urandom_range(0, 5) == 0 && n0 > 1) ab = int'($urandom_range(1, 2));
      job(n0, hold, ab, hv[0]);
    end

    job_small(27);
    job_small(1);
    job_small(0);
    job_small(65535);
    for (int i = 0; i < 10; i++) job_small(int'($urandom_range(0, 65535)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
